// File: rtl/kd_pkg.sv
// Shared kd-tree types and size helpers for the nearest-neighbour datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kd_pkg;

    // Tracker FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bits needed for a single coordinate
    function automatic int calc_dim_size(input int data_range);
        return $clog2(data_range);
    endfunction

    // Bits needed for a full Manhattan distance over all axes
    function automatic int calc_dist_size(input int dim, input int data_range);
        return $clog2(data_range * dim);
    endfunction

    // Bits needed for a packed center (all coordinates)
    function automatic int calc_center_size(input int dim, input int data_range);
        return dim * calc_dim_size(data_range);
    endfunction

    // "No best yet" distance: all ones at the given width (w in 1..32)
    function automatic logic [31:0] best_dist_rst(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

endpackage

// File: rtl/dist_min_cmp.sv
// Distance compare: strict less-than, running minimum and prune flag.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module dist_min_cmp #(
    parameter int dist_w   = 10,
    parameter int single_w = 8
) (
    input  logic [dist_w-1:0]   best_dist,
    input  logic [dist_w-1:0]   cand_dist,
    input  logic [single_w-1:0] single_dist,
    output logic                lt,
    output logic [dist_w-1:0]   min_dist,
    output logic                prune
);

    logic [dist_w-1:0] single_ext;

    // Strict compare keeps the earlier candidate on ties; prune tests the plane
    // distance against the best including this candidate.
    always_comb begin
        single_ext = dist_w'(single_dist);
        lt         = cand_dist < best_dist;
        min_dist   = lt ? cand_dist : best_dist;
        prune      = single_ext >= min_dist;
    end

endmodule

// File: rtl/nn_best_tracker.sv
// Tracks the nearest center per query and issues per-node prune decisions.
// Latency: prune and best_* one cycle after accept; done one cycle after last accept.
// Backpressure: in_ready only in TRACK and not during start; one candidate per cycle.
module nn_best_tracker
    import kd_pkg::*;
#(
    parameter int dim        = 3,
    parameter int data_range = 255,
    parameter int visit_w    = 8
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [calc_center_size(dim, data_range)-1:0]        in_center,
    input  logic [calc_dist_size(dim, data_range)-1:0]          in_dist,
    input  logic [calc_dim_size(data_range)-1:0]                in_single_dist,
    input  logic                                                in_last,
    output logic                                                prune_valid,
    output logic                                                prune,
    output logic [calc_center_size(dim, data_range)-1:0]        best_center,
    output logic [calc_dist_size(dim, data_range)-1:0]          best_dist,
    output logic [visit_w-1:0]                                  visit_count,
    output logic                                                busy,
    output logic                                                done
);

    localparam int dim_size    = calc_dim_size(data_range);
    localparam int dist_size   = calc_dist_size(dim, data_range);
    localparam int center_size = calc_center_size(dim, data_range);
    localparam logic [dist_size-1:0] BEST_RST = dist_size'(best_dist_rst(dist_size));

    state_e                 state_q, state_d;
    logic [dist_size-1:0]   best_dist_q, best_dist_d;
    logic [center_size-1:0] best_center_q, best_center_d;
    logic [visit_w-1:0]     visit_count_q, visit_count_d;
    logic                   prune_q, prune_d;
    logic                   prune_valid_q, prune_valid_d;

    logic                   accept;
    logic                   cand_lt;
    logic [dist_size-1:0]   cand_min;
    logic                   cand_prune;

    dist_min_cmp #(
        .dist_w   (dist_size),
        .single_w (dim_size)
    ) u_cmp (
        .best_dist   (best_dist_q),
        .cand_dist   (in_dist),
        .single_dist (in_single_dist),
        .lt          (cand_lt),
        .min_dist    (cand_min),
        .prune       (cand_prune)
    );

    // Handshake: start in TRACK takes priority over any candidate that cycle
    always_comb begin
        in_ready = (state_q == ST_TRACK) && !start;
        accept   = in_valid && in_ready;
    end

    // Next-state: query control, best update, saturating count, prune decision
    always_comb begin
        state_d       = state_q;
        best_dist_d   = best_dist_q;
        best_center_d = best_center_q;
        visit_count_d = visit_count_q;
        prune_d       = prune_q;
        prune_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_TRACK;
                    best_dist_d   = BEST_RST;
                    best_center_d = '0;
                    visit_count_d = '0;
                end
            end
            ST_TRACK: begin
                if (start) begin
                    best_dist_d   = BEST_RST;
                    best_center_d = '0;
                    visit_count_d = '0;
                end else if (accept) begin
                    best_dist_d   = cand_min;
                    if (cand_lt) begin
                        best_center_d = in_center;
                    end
                    if (visit_count_q != '1) begin
                        visit_count_d = visit_count_q + 1'b1;
                    end
                    prune_d       = cand_prune;
                    prune_valid_d = 1'b1;
                    if (in_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any query in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            best_dist_q   <= BEST_RST;
            best_center_q <= '0;
            visit_count_q <= '0;
            prune_q       <= 1'b0;
            prune_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            best_dist_q   <= best_dist_d;
            best_center_q <= best_center_d;
            visit_count_q <= visit_count_d;
            prune_q       <= prune_d;
            prune_valid_q <= prune_valid_d;
        end
    end

    assign best_dist   = best_dist_q;
    assign best_center = best_center_q;
    assign visit_count = visit_count_q;
    assign prune       = prune_q;
    assign prune_valid = prune_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: doc/nn_best_tracker.md
# nn_best_tracker

Downstream consumer of the kd-tree Manhattan distance stage. Per nearest-neighbour query it accepts a stream of visited tree nodes, each with its full Manhattan distance to the query point and its single-axis (splitting-plane) distance. It keeps the running best center and distance. After each node it returns a registered prune decision to the traversal controller, and it reports the final nearest center with a one-cycle done pulse.

## Interface
Parameters:
- dim, 3, number of coordinates per center
- data_range, 255, maximum coordinate value
- visit_w, 8, width of the saturating visited-node counter
- Derived localparams: dim_size = $clog2(data_range); dist_size = $clog2(data_range*dim); center_size = dim*dim_size

Ports:
- clk  in  1  sole clock; all state is updated on the rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a new query; clears the tracked best
- in_valid  in  1  candidate present
- in_ready  out  1  candidate accepted on the edge where in_valid & in_ready
- in_center  in  center_size  candidate center coordinates
- in_dist  in  dist_size  full Manhattan distance of the candidate
- in_single_dist  in  dim_size  distance to the splitting plane on the current axis
- in_last  in  1  final candidate of the query
- prune_valid  out  1  one-cycle pulse; prune is meaningful
- prune  out  1  1 = the far branch cannot improve the result and is skipped
- best_center  out  center_size  current best center
- best_dist  out  dist_size  current best distance
- visit_count  out  visit_w  candidates accepted this query, saturating
- busy  out  1  high in TRACK and DONE
- done  out  1  one-cycle pulse; result is final

## Operation
- FSM states: IDLE, TRACK, DONE.
- IDLE:
  - in_ready = 0.
  - start -> TRACK, with best_dist <= all ones, best_center <= 0, visit_count <= 0.
- TRACK:
  - in_ready = ~start.
  - On accept:
    - If in_dist < best_dist (strict), load best_dist and best_center from the candidate. On a tie the earlier candidate is kept.
    - visit_count increments and saturates at 2^visit_w - 1.
    - prune <= ({0, in_single_dist} >= min(best_dist, in_dist)). in_single_dist is zero-extended to dist_size, and the comparison uses the post-update best.
    - prune_valid <= 1.
  - Accept with in_last -> DONE.
  - start while in TRACK restarts the query: the best is cleared as in IDLE and no candidate is accepted that cycle.
- DONE:
  - done = 1 for one cycle, then the FSM returns to IDLE.
  - in_ready = 0.
  - start is ignored in this state.
- best_center, best_dist and visit_count hold after done until the next start.
- A query with no improving candidate still terminates on in_last, reporting best_dist = all ones and best_center = 0.

## Timing
- Reset values: in_ready 0, prune 0, prune_valid 0, best_center 0, best_dist all ones (1023 at defaults), visit_count 0, busy 0, done 0; state IDLE.
- Reset mid-query aborts immediately. No done pulse follows.
- Accept on edge N:
  - best_* and visit_count are updated after edge N.
  - prune and prune_valid are high during cycle N+1.
- Throughput is one candidate per cycle in TRACK, with back-to-back accepts allowed.
- Last accepted on edge N:
  - done is high during cycle N+1, with best_* final.
  - in_ready is low from cycle N+1.
  - The earliest new start is sampled in cycle N+2.
- prune is a registered output, held between pulses; prune_valid is the qualifier.
- All comparisons are unsigned at width dist_size.

## Structure
- Shared package kd_pkg holds dim_size, dist_size and center_size as functions of dim and data_range, the FSM state enum, and the best_dist reset constant (all ones).
- One combinational sub-module, dist_min_cmp, produces the "less than" flag, min(best, in) and the prune flag. It is reusable by the traversal controller.

## Test plan
- start, then dists 300, 120, 200 with in_last on the third -> best_dist 120, best_center = the second center, visit_count 3, done exactly one cycle after the third accept.
- Tie: dists 50 then 50 -> best_center = the first center.
- Prune boundary, best 40:
  - candidate dist 90, single 40 -> prune 1 in the next cycle.
  - single 39 -> prune 0.
  - candidate dist 10, single 20 -> prune 1 (post-update best 10).
- rst asserted mid-TRACK -> all outputs at reset values, no done pulse; the next query after start behaves normally.
- start high with in_valid during TRACK -> in_ready 0 that cycle, best_dist 1023, visit_count 0, no prune_valid pulse.
- visit_w = 2, five candidates -> visit_count saturates at 3, and best is still the correct minimum.
